// File: rtl/lutram_wr_arbiter_init.sv
// Write-port owner for a 1W/1R LUTRAM: init sweep over [lo..hi], round-robin
// sharing between two write clients, and a registered write-first read port.
//
// state   | meaning
// ST_INIT | sweeping init_value into [lo..hi]; clients and reader held off
// ST_RUN  | normal operation; round-robin write grants, reads accepted
module lutram_wr_arbiter_init #(
    parameter int addr_width = 4,
    parameter int data_width = 8,
    parameter int lo = 0,
    parameter int hi = 15,
    parameter logic [data_width-1:0] init_value = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  USER_RST,
    output logic                  INIT_DONE,
    input  logic                  WA_VALID,
    input  logic [addr_width-1:0] WA_ADDR,
    input  logic [data_width-1:0] WA_DATA,
    output logic                  WA_READY,
    input  logic                  WB_VALID,
    input  logic [addr_width-1:0] WB_ADDR,
    input  logic [data_width-1:0] WB_DATA,
    output logic                  WB_READY,
    input  logic                  RD_EN,
    input  logic [addr_width-1:0] RD_ADDR,
    output logic                  RD_RDY,
    output logic                  RD_VALID,
    output logic [data_width-1:0] RD_DATA,
    output logic [addr_width-1:0] RAM_ADDR_IN,
    output logic [data_width-1:0] RAM_D_IN,
    output logic                  RAM_WE,
    output logic [addr_width-1:0] RAM_ADDR_1,
    input  logic [data_width-1:0] RAM_D_OUT_1
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

    state_t                  state, state_next;
    logic [addr_width-1:0]   cnt, cnt_next;
    logic                    prio_b, prio_next;
    logic                    rd_valid_q;
    logic [data_width-1:0]   rd_data_q;
    logic                    grant_a, grant_b;
    logic                    rd_fire, rd_fwd;

    assign INIT_DONE  = (state == ST_RUN);
    assign RD_RDY     = INIT_DONE;
    assign RD_VALID   = rd_valid_q;
    assign RD_DATA    = rd_data_q;
    assign RAM_ADDR_1 = RD_ADDR;

    // prio_b = 0 means A wins a contested cycle
    assign grant_a  = INIT_DONE && WA_VALID && (!WB_VALID || !prio_b);
    assign grant_b  = INIT_DONE && WB_VALID && (!WA_VALID || prio_b);
    assign WA_READY = grant_a;
    assign WB_READY = grant_b;

    assign rd_fire = RD_EN && RD_RDY;
    assign rd_fwd  = RAM_WE && (RAM_ADDR_IN == RD_ADDR);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_INIT;
            cnt        <= LO_A;
            prio_b     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            prio_b     <= prio_next;
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_fwd ? RAM_D_IN : RAM_D_OUT_1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        prio_next   = prio_b;
        RAM_WE      = 1'b0;
        RAM_ADDR_IN = '0;
        RAM_D_IN    = '0;
        case (state)
            ST_INIT: begin
                RAM_WE      = 1'b1;
                RAM_ADDR_IN = cnt;
                RAM_D_IN    = init_value;
                if (USER_RST) begin
                    cnt_next = LO_A;
                end else if (cnt == HI_A) begin
                    state_next = ST_RUN;
                    cnt_next   = LO_A;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (grant_a) begin
                    RAM_WE      = 1'b1;
                    RAM_ADDR_IN = WA_ADDR;
                    RAM_D_IN    = WA_DATA;
                    prio_next   = 1'b1;
                end else if (grant_b) begin
                    RAM_WE      = 1'b1;
                    RAM_ADDR_IN = WB_ADDR;
                    RAM_D_IN    = WB_DATA;
                    prio_next   = 1'b0;
                end
                // a grant in this cycle still lands before the re-sweep starts
                if (USER_RST) begin
                    state_next = ST_INIT;
                    cnt_next   = LO_A;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = LO_A;
            end
        endcase
    end

endmodule

// File: tb/tb_lutram_wr_arbiter_init.sv
// Bench for lutram_wr_arbiter_init: LUTRAM model on the RAM ports, read
// expectations queued at issue and popped when RD_VALID is sampled.
module tb_lutram_wr_arbiter_init;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       user_rst = 1'b0;
    logic       init_done;
    logic       wa_valid = 1'b0, wb_valid = 1'b0;
    logic [3:0] wa_addr = '0, wb_addr = '0;
    logic [7:0] wa_data = '0, wb_data = '0;
    logic       wa_ready, wb_ready;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;
    logic       rd_rdy, rd_valid;
    logic [7:0] rd_data;
    logic [3:0] ram_addr_in, ram_addr_1;
    logic [7:0] ram_d_in, ram_d_out_1;
    logic       ram_we;

    logic [7:0] ram [16];
    logic [7:0] exp_mem [16];
    logic [7:0] rd_q [$];
    logic [7:0] exp_d;
    logic       exp_prio_b;
    logic       ga;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram[ram_addr_in] <= ram_d_in;
    assign ram_d_out_1 = ram[ram_addr_1];

    lutram_wr_arbiter_init #(
        .addr_width(4), .data_width(8), .lo(0), .hi(15), .init_value(8'hA5)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .USER_RST(user_rst), .INIT_DONE(init_done),
        .WA_VALID(wa_valid), .WA_ADDR(wa_addr), .WA_DATA(wa_data), .WA_READY(wa_ready),
        .WB_VALID(wb_valid), .WB_ADDR(wb_addr), .WB_DATA(wb_data), .WB_READY(wb_ready),
        .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_RDY(rd_rdy), .RD_VALID(rd_valid),
        .RD_DATA(rd_data), .RAM_ADDR_IN(ram_addr_in), .RAM_D_IN(ram_d_in),
        .RAM_WE(ram_we), .RAM_ADDR_1(ram_addr_1), .RAM_D_OUT_1(ram_d_out_1)
    );

    task automatic test_reset();
        rst_n = 1'b0; user_rst = 1'b1; wa_valid = 1'b1; wb_valid = 1'b1; rd_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", init_done); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_cmp++; if ({wa_ready, wb_ready, rd_rdy} !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", {wa_ready, wb_ready, rd_rdy}); end
        n_cmp++; if (ram_addr_in !== 4'd0 || ram_we !== 1'b1) begin n_fail++; $display("FAIL reset_ram got we=%b addr=%0d want we=1 addr=0", ram_we, ram_addr_in); end
        user_rst = 1'b0; wa_valid = 1'b0; wb_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_init_sweep();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++; if (ram_we !== 1'b1 || ram_addr_in !== 4'(k) || ram_d_in !== 8'hA5)
                begin n_fail++; $display("FAIL sweep_write[%0d] got we=%b addr=%0d d=%h want we=1 addr=%0d d=a5", k, ram_we, ram_addr_in, ram_d_in, k); end
            n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_early[%0d] got %b want 0", k, init_done); end
        end
        @(negedge clk); #1;
        n_cmp++; if (init_done !== 1'b1 || rd_rdy !== 1'b1) begin n_fail++; $display("FAIL sweep_done got done=%b rdy=%b want 1 1", init_done, rd_rdy); end
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL idle_we got %b want 0", ram_we); end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hA5;
        exp_prio_b = 1'b0;
    endtask

    task automatic test_read_all();
        for (int a = 0; a <= 16; a++) begin
            @(negedge clk);
            if (a > 0) begin
                exp_d = rd_q.pop_front();
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d)
                    begin n_fail++; $display("FAIL read_all[%0d] got v=%b d=%h want v=1 d=%h", a - 1, rd_valid, rd_data, exp_d); end
            end
            if (a < 16) begin
                rd_en = 1'b1; rd_addr = 4'(a); rd_q.push_back(exp_mem[a]);
            end else rd_en = 1'b0;
            #1;
            n_cmp++; if (ram_addr_1 !== rd_addr) begin n_fail++; $display("FAIL ram_addr_1 got %0d want %0d", ram_addr_1, rd_addr); end
        end
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL read_idle_valid got %b want 0", rd_valid); end
    endtask

    task automatic test_arb_alternate();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wa_valid = 1'b1; wa_addr = 4'd3; wa_data = 8'h11;
            wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 8'h22;
            #1;
            ga = !exp_prio_b;
            n_cmp++; if (wa_ready !== ga || wb_ready !== !ga)
                begin n_fail++; $display("FAIL alt_grant[%0d] got a=%b b=%b want a=%b b=%b", i, wa_ready, wb_ready, ga, !ga); end
            n_cmp++; if (ram_we !== 1'b1 || ram_addr_in !== (ga ? 4'd3 : 4'd7) || ram_d_in !== (ga ? 8'h11 : 8'h22))
                begin n_fail++; $display("FAIL alt_write[%0d] got we=%b addr=%0d d=%h", i, ram_we, ram_addr_in, ram_d_in); end
            exp_prio_b = ga;
        end
        exp_mem[3] = 8'h11; exp_mem[7] = 8'h22;
        @(negedge clk);
        wa_valid = 1'b0; wb_valid = 1'b0;
        #1;
        n_cmp++; if (ram_we !== 1'b0 || wa_ready !== 1'b0 || wb_ready !== 1'b0 || ram_addr_in !== 4'd0)
            begin n_fail++; $display("FAIL alt_idle got we=%b a=%b b=%b addr=%0d want 0 0 0 0", ram_we, wa_ready, wb_ready, ram_addr_in); end
    endtask

    task automatic test_b_only();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_addr = 4'd8; wb_data = (i < 3) ? 8'(8'h80 + i) : 8'h8F;
            wa_valid = (i >= 3); wa_addr = 4'd9; wa_data = 8'h99;
            #1;
            ga = (i == 3);
            n_cmp++; if (wa_ready !== ga || wb_ready !== !ga)
                begin n_fail++; $display("FAIL bonly_grant[%0d] got a=%b b=%b want a=%b b=%b", i, wa_ready, wb_ready, ga, !ga); end
            n_cmp++; if (ram_addr_in !== (ga ? 4'd9 : 4'd8) || ram_d_in !== (ga ? 8'h99 : wb_data))
                begin n_fail++; $display("FAIL bonly_write[%0d] got addr=%0d d=%h", i, ram_addr_in, ram_d_in); end
        end
        exp_mem[8] = 8'h8F; exp_mem[9] = 8'h99; exp_prio_b = 1'b0;
        @(negedge clk);
        wa_valid = 1'b0; wb_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd8; rd_q.push_back(exp_mem[8]);
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL bonly_read8 got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        rd_addr = 4'd9; rd_q.push_back(exp_mem[9]);
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL bonly_read9 got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        rd_en = 1'b0;
    endtask

    task automatic test_forward();
        @(negedge clk);
        wa_valid = 1'b1; wa_addr = 4'd5; wa_data = 8'h3C;
        rd_en = 1'b1; rd_addr = 4'd5; rd_q.push_back(8'h3C);
        #1;
        n_cmp++; if (wa_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_grant got %b want 1", wa_ready); end
        exp_mem[5] = 8'h3C;
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL fwd_same_addr got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        wa_data = 8'h4D; rd_addr = 4'd6; rd_q.push_back(exp_mem[6]);
        exp_mem[5] = 8'h4D;
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL fwd_other_addr got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        wa_valid = 1'b0; rd_addr = 4'd5; rd_q.push_back(exp_mem[5]);
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL fwd_readback got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        rd_en = 1'b0;
        exp_prio_b = 1'b1;
    endtask

    task automatic test_user_rst_run();
        @(negedge clk);
        wa_valid = 1'b1; wa_addr = 4'd2; wa_data = 8'h77; user_rst = 1'b1;
        #1;
        n_cmp++; if (wa_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr_in !== 4'd2 || ram_d_in !== 8'h77)
            begin n_fail++; $display("FAIL urst_write got rdy=%b we=%b addr=%0d d=%h want 1 1 2 77", wa_ready, ram_we, ram_addr_in, ram_d_in); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            user_rst = 1'b0; rd_en = 1'b1; rd_addr = 4'(k);
            #1;
            n_cmp++; if (init_done !== 1'b0 || wa_ready !== 1'b0 || rd_rdy !== 1'b0)
                begin n_fail++; $display("FAIL urst_held[%0d] got done=%b wa_rdy=%b rd_rdy=%b want 0 0 0", k, init_done, wa_ready, rd_rdy); end
            n_cmp++; if (ram_addr_in !== 4'(k) || ram_d_in !== 8'hA5)
                begin n_fail++; $display("FAIL urst_sweep[%0d] got addr=%0d d=%h want %0d a5", k, ram_addr_in, ram_d_in, k); end
            n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h4D)
                begin n_fail++; $display("FAIL urst_drop[%0d] got v=%b d=%h want 0 4d", k, rd_valid, rd_data); end
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hA5;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b0 || init_done !== 1'b1) begin n_fail++; $display("FAIL urst_end got v=%b done=%b want 0 1", rd_valid, init_done); end
        wa_valid = 1'b0; rd_addr = 4'd2; rd_q.push_back(exp_mem[2]);
        @(negedge clk);
        exp_d = rd_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin n_fail++; $display("FAIL urst_read2 got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_d); end
        rd_en = 1'b0;
    endtask

    task automatic test_user_rst_init();
        @(negedge clk);
        user_rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            user_rst = (k == 9);
            #1;
            n_cmp++; if (ram_addr_in !== 4'(k)) begin n_fail++; $display("FAIL uinit_pre[%0d] got addr=%0d want %0d", k, ram_addr_in, k); end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            user_rst = 1'b0;
            #1;
            n_cmp++; if (ram_addr_in !== 4'(k) || init_done !== 1'b0)
                begin n_fail++; $display("FAIL uinit_restart[%0d] got addr=%0d done=%b want %0d 0", k, ram_addr_in, init_done, k); end
        end
        @(negedge clk); #1;
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL uinit_done got %b want 1", init_done); end
    endtask

    task automatic test_rst_override();
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd0;
        @(negedge clk);
        rst_n = 1'b0; user_rst = 1'b1; rd_en = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (init_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || ram_addr_in !== 4'd0)
            begin n_fail++; $display("FAIL rst_override got done=%b v=%b d=%h addr=%0d want 0 0 00 0", init_done, rd_valid, rd_data, ram_addr_in); end
        rst_n = 1'b1; user_rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'hEE;
        test_reset();
        test_init_sweep();
        test_read_all();
        test_arb_alternate();
        test_b_only();
        test_forward();
        test_user_rst_run();
        test_user_rst_init();
        test_rst_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
